// File: rtl/block_layer_pkg.sv
// Shared types for the block-sprite layer: descriptor record, palette codes and
// the per-channel palette expansion helper.
package block_layer_pkg;

  localparam int COORD_W = 11;
  localparam int REL_W   = 12;

  typedef struct packed {
    logic [COORD_W-1:0] xs;
    logic [COORD_W-1:0] ys;
    logic [2:0]         color;
    logic               vis;
    logic               flash;
  } desc_t;

  typedef enum logic [1:0] {
    PLT_KEY   = 2'b00,
    PLT_WHITE = 2'b01,
    PLT_DIM   = 2'b10,
    PLT_FULL  = 2'b11
  } plt_code_t;

  // Returns {msb, rest}: the channel is the msb bit followed by W-1 copies of rest.
  function automatic logic [1:0] plt_chan(plt_code_t code, logic cbit);
    logic [1:0] r;
    case (code)
      PLT_WHITE: r = 2'b11;
      PLT_DIM:   r = {1'b0, cbit};
      PLT_FULL:  r = {cbit, cbit};
      default:   r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/block_layer_src_hit_sel.sv
// Combinational priority search over all block descriptors; the lowest enabled
// index whose square covers the scan pixel wins.
module block_hit_sel
  import block_layer_pkg::*;
#(
  parameter int N_BLK    = 15,
  parameter int BLK_LOG2 = 5,
  parameter int IDXW     = 4
) (
  input  logic [COORD_W-1:0]  x_i,
  input  logic [COORD_W-1:0]  y_i,
  input  logic [COORD_W-1:0]  xs_i [N_BLK],
  input  logic [COORD_W-1:0]  ys_i [N_BLK],
  input  logic [N_BLK-1:0]    en_i,
  output logic                hit_o,
  output logic [IDXW-1:0]     idx_o,
  output logic [BLK_LOG2-1:0] xr_o,
  output logic [BLK_LOG2-1:0] yr_o
);

  logic [REL_W-1:0] xr_a [N_BLK];
  logic [REL_W-1:0] yr_a [N_BLK];
  logic [N_BLK-1:0] in_a;

  // Sign bit and all bits above the block edge must be clear for 0 <= rel < 2**BLK_LOG2.
  for (genvar i = 0; i < N_BLK; i++) begin : g_rel
    assign xr_a[i] = {1'b0, x_i} - {1'b0, xs_i[i]};
    assign yr_a[i] = {1'b0, y_i} - {1'b0, ys_i[i]};
    assign in_a[i] = en_i[i]
                   && (xr_a[i][REL_W-1:BLK_LOG2] == '0)
                   && (yr_a[i][REL_W-1:BLK_LOG2] == '0);
  end

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    xr_o  = '0;
    yr_o  = '0;
    for (int i = N_BLK - 1; i >= 0; i--) begin
      if (in_a[i]) begin
        hit_o = 1'b1;
        idx_o = IDXW'(i);
        xr_o  = xr_a[i][BLK_LOG2-1:0];
        yr_o  = yr_a[i][BLK_LOG2-1:0];
      end
    end
  end

endmodule

// File: rtl/block_ram_lut.sv
// Simple dual-port synchronous RAM; a read colliding with a write returns the old word.
module block_ram_lut #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_w_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic [ADDR_WIDTH-1:0] addr_r_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_w_i] <= din_i;
    dout_o <= mem_q[addr_r_i];
  end

endmodule

// File: rtl/block_layer_src.sv
// Block-sprite layer: descriptor table, priority hit search, sprite RAM lookup and
// palette resolve in a 3-stage pipeline. BLOCK_LAYER_FLASH_EN enables per-block flashing.
module block_layer_src
  import block_layer_pkg::*;
#(
  parameter int            N_BLK     = 15,
  parameter int            CD        = 12,
  parameter int            BLK_LOG2  = 5,
  parameter logic [CD-1:0] KEY_COLOR = '0,
  parameter int            FLASH_DIV = 8,
  localparam int           IDXW      = (N_BLK > 1) ? $clog2(N_BLK) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic                  frame_tick,
  input  logic                  desc_we,
  input  logic [IDXW-1:0]       desc_idx,
  input  logic [10:0]           desc_xs,
  input  logic [10:0]           desc_ys,
  input  logic [2:0]            desc_color,
  input  logic                  desc_vis,
  input  logic                  desc_flash,
  input  logic                  spr_we,
  input  logic [2*BLK_LOG2-1:0] spr_addr_w,
  input  logic [1:0]            spr_pixel_in,
  output logic [CD-1:0]         sprite_rgb,
  output logic                  sprite_hit
);

  localparam int AW = 2 * BLK_LOG2;
  localparam int W  = CD / 3;

  desc_t desc_q [N_BLK];
  desc_t desc_wr;
  logic  flash_phase;

  assign desc_wr = '{xs: desc_xs, ys: desc_ys, color: desc_color, vis: desc_vis, flash: desc_flash};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BLK; i++) desc_q[i] <= '0;
    end else if (desc_we) begin
      for (int i = 0; i < N_BLK; i++)
        if (desc_idx == IDXW'(i)) desc_q[i] <= desc_wr;
    end
  end

`ifdef BLOCK_LAYER_FLASH_EN
  localparam int FCW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  logic [FCW-1:0] flash_cnt_q, flash_cnt_d;
  logic           flash_phase_q, flash_phase_d;

  always_comb begin
    flash_cnt_d   = flash_cnt_q;
    flash_phase_d = flash_phase_q;
    if (frame_tick) begin
      if (flash_cnt_q == FCW'(FLASH_DIV - 1)) begin
        flash_cnt_d   = '0;
        flash_phase_d = ~flash_phase_q;
      end else begin
        flash_cnt_d = flash_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
    end else begin
      flash_cnt_q   <= flash_cnt_d;
      flash_phase_q <= flash_phase_d;
    end
  end

  assign flash_phase = flash_phase_q;
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign flash_phase       = 1'b0;
`endif

  // Stage 0: hit search on the pre-write descriptor table.
  logic [10:0]         xs_a [N_BLK];
  logic [10:0]         ys_a [N_BLK];
  logic [N_BLK-1:0]    en_a;
  logic                hit_s0;
  logic [IDXW-1:0]     idx_s0;
  logic [BLK_LOG2-1:0] xr_s0, yr_s0;
  logic [2:0]          color_s0;

  always_comb begin
    for (int i = 0; i < N_BLK; i++) begin
      xs_a[i] = desc_q[i].xs;
      ys_a[i] = desc_q[i].ys;
      en_a[i] = desc_q[i].vis & ~(desc_q[i].flash & flash_phase);
    end
  end

  block_hit_sel #(.N_BLK(N_BLK), .BLK_LOG2(BLK_LOG2), .IDXW(IDXW)) u_hit_sel (
    .x_i   (x),
    .y_i   (y),
    .xs_i  (xs_a),
    .ys_i  (ys_a),
    .en_i  (en_a),
    .hit_o (hit_s0),
    .idx_o (idx_s0),
    .xr_o  (xr_s0),
    .yr_o  (yr_s0)
  );

  always_comb begin
    color_s0 = 3'b000;
    for (int i = 0; i < N_BLK; i++)
      if (idx_s0 == IDXW'(i)) color_s0 = desc_q[i].color;
  end

  // Stage 1/2/3 pipeline registers.
  logic          hit1_q, hit1_d, hit2_q, hit3_q, hit3_d;
  logic [2:0]    color1_q, color1_d, color2_q;
  logic [AW-1:0] addr1_q, addr1_d;
  logic [CD-1:0] rgb3_q, rgb3_d, rgb_res;
  logic [1:0]    ram_rd;
  plt_code_t     code2;

  always_comb begin
    hit1_d   = hit_s0;
    color1_d = hit_s0 ? color_s0 : 3'b000;
    addr1_d  = hit_s0 ? {yr_s0, xr_s0} : '0;
  end

  block_ram_lut #(.DATA_WIDTH(2), .ADDR_WIDTH(AW)) u_spr_ram (
    .clk_i    (clk),
    .we_i     (spr_we),
    .addr_w_i (spr_addr_w),
    .din_i    (spr_pixel_in),
    .addr_r_i (addr1_q),
    .dout_o   (ram_rd)
  );

  assign code2 = plt_code_t'(ram_rd);

  // Channel c=0 is red (top bits), driven by color bit 2.
  for (genvar c = 0; c < 3; c++) begin : g_chan
    logic [1:0] pc;
    assign pc = plt_chan(code2, color2_q[2-c]);
    assign rgb_res[CD-1-c*W -: W] = {pc[1], {(W-1){pc[0]}}};
  end

  always_comb begin
    rgb3_d = KEY_COLOR;
    hit3_d = 1'b0;
    if (hit2_q && code2 != PLT_KEY) begin
      rgb3_d = rgb_res;
      hit3_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit1_q   <= 1'b0;
      color1_q <= 3'b000;
      addr1_q  <= '0;
      hit2_q   <= 1'b0;
      color2_q <= 3'b000;
      hit3_q   <= 1'b0;
      rgb3_q   <= KEY_COLOR;
    end else begin
      hit1_q   <= hit1_d;
      color1_q <= color1_d;
      addr1_q  <= addr1_d;
      hit2_q   <= hit1_q;
      color2_q <= color1_q;
      hit3_q   <= hit3_d;
      rgb3_q   <= rgb3_d;
    end
  end

  assign sprite_rgb = rgb3_q;
  assign sprite_hit = hit3_q;

endmodule

// File: tb/tb_block_layer_src.sv
// Scoreboard bench for block_layer_src: the driver queues hand-computed pixels,
// a negedge monitor compares each one three clocks after issue.
module tb_block_layer_src;

  localparam int N_BLK = 15, CD = 12, BLK_LOG2 = 5, FLASH_DIV = 2;
  localparam logic [11:0] KEY = 12'h000;

  logic        clk = 1'b0, reset = 1'b1;
  logic [10:0] x = '0, y = '0, desc_xs = '0, desc_ys = '0;
  logic        frame_tick = 1'b0, desc_we = 1'b0, desc_vis = 1'b0, desc_flash = 1'b0;
  logic [3:0]  desc_idx = '0;
  logic [2:0]  desc_color = '0;
  logic        spr_we = 1'b0;
  logic [9:0]  spr_addr_w = '0;
  logic [1:0]  spr_pixel_in = '0;
  logic [11:0] sprite_rgb;
  logic        sprite_hit;

  block_layer_src #(.N_BLK(N_BLK), .CD(CD), .BLK_LOG2(BLK_LOG2), .KEY_COLOR(KEY),
                    .FLASH_DIV(FLASH_DIV)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .frame_tick(frame_tick),
    .desc_we(desc_we), .desc_idx(desc_idx), .desc_xs(desc_xs), .desc_ys(desc_ys),
    .desc_color(desc_color), .desc_vis(desc_vis), .desc_flash(desc_flash),
    .spr_we(spr_we), .spr_addr_w(spr_addr_w), .spr_pixel_in(spr_pixel_in),
    .sprite_rgb(sprite_rgb), .sprite_hit(sprite_hit)
  );

  typedef struct {
    int          due;
    int          tag;
    logic        hit;
    logic [11:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0, n_chk = 0, n_fail = 0, tag_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {hit,rgb}=%h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check($sformatf("pix%0d", e.tag), {sprite_hit, sprite_rgb}, {e.hit, e.rgb});
    end
  end

  task automatic pix(input int px, input int py, input logic eh, input logic [11:0] er);
    exp_t e;
    x = 11'(px);
    y = 11'(py);
    e.due = cyc + 3; e.tag = tag_n; e.hit = eh; e.rgb = er;
    exp_q.push_back(e);
    tag_n++;
    @(negedge clk);
  endtask

  task automatic set_desc(input int idx, input int xs, input int ys, input logic [2:0] col,
                          input logic vis, input logic fl);
    desc_we = 1'b1; desc_idx = 4'(idx); desc_xs = 11'(xs); desc_ys = 11'(ys);
    desc_color = col; desc_vis = vis; desc_flash = fl;
    @(negedge clk);
    desc_we = 1'b0;
  endtask

  task automatic spr_wr(input int addr, input logic [1:0] d);
    spr_we = 1'b1; spr_addr_w = 10'(addr); spr_pixel_in = d;
    @(negedge clk);
    spr_we = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    check("reset_out", {sprite_hit, sprite_rgb}, {1'b0, KEY});
    @(negedge clk);
    reset = 1'b0;

    // 1: empty table gives key colour everywhere
    pix(0, 0, 1'b0, KEY);
    pix(100, 50, 1'b0, KEY);
    pix(2047, 2047, 1'b0, KEY);
    pix(31, 31, 1'b0, KEY);
    pix(500, 300, 1'b0, KEY);
    pix(1, 1, 1'b0, KEY);
    drain();

    for (int a = 0; a < 1024; a++) spr_wr(a, 2'b11);

    // 2: single block, edges of the 32x32 square
    set_desc(0, 100, 50, 3'b101, 1'b1, 1'b0);
    pix(100, 50, 1'b1, 12'hF0F);
    pix(131, 81, 1'b1, 12'hF0F);
    pix(132, 50, 1'b0, KEY);
    pix(99, 50, 1'b0, KEY);
    pix(100, 82, 1'b0, KEY);
    pix(100, 49, 1'b0, KEY);

    // 3: overlapping blocks, lowest index wins
    set_desc(2, 200, 200, 3'b001, 1'b1, 1'b0);
    set_desc(5, 200, 200, 3'b010, 1'b1, 1'b0);
    pix(210, 210, 1'b1, 12'h00F);
    set_desc(2, 200, 200, 3'b001, 1'b0, 1'b0);
    pix(210, 210, 1'b1, 12'h0F0);

    // 4: palette codes and RAM addressing
    set_desc(0, 0, 0, 3'b111, 1'b1, 1'b0);
    spr_wr({5'd3, 5'd4}, 2'b10);
    spr_wr({5'd3, 5'd5}, 2'b00);
    spr_wr({5'd10, 5'd10}, 2'b01);
    pix(4, 3, 1'b1, 12'h777);
    pix(5, 3, 1'b0, KEY);
    pix(6, 3, 1'b1, 12'hFFF);
    pix(210, 210, 1'b1, 12'hFFF);
    pix(204, 203, 1'b1, 12'h070);
    // read-during-write of the same RAM word returns the old code
    pix(4, 3, 1'b1, 12'h777);
    spr_we = 1'b1; spr_addr_w = {5'd3, 5'd4}; spr_pixel_in = 2'b11;
    pix(0, 0, 1'b1, 12'hFFF);
    spr_we = 1'b0;
    pix(4, 3, 1'b1, 12'hFFF);

    // 5: flashing block over a steady one
    set_desc(3, 300, 300, 3'b011, 1'b1, 1'b0);
    set_desc(1, 300, 300, 3'b100, 1'b1, 1'b1);
    pix(305, 305, 1'b1, 12'hF00);
    tick();
    pix(305, 305, 1'b1, 12'hF00);
    tick();
`ifdef BLOCK_LAYER_FLASH_EN
    pix(305, 305, 1'b1, 12'h0FF);
`else
    pix(305, 305, 1'b1, 12'hF00);
`endif
    tick();
    tick();
    pix(305, 305, 1'b1, 12'hF00);

    // 6: same-cycle descriptor write, out-of-range index
    desc_we = 1'b1; desc_idx = 4'd0; desc_xs = 11'd0; desc_ys = 11'd0;
    desc_color = 3'b010; desc_vis = 1'b1; desc_flash = 1'b0;
    pix(0, 0, 1'b1, 12'hFFF);
    desc_we = 1'b0;
    pix(0, 0, 1'b1, 12'h0F0);
    set_desc(15, 500, 500, 3'b100, 1'b1, 1'b0);
    pix(500, 500, 1'b0, KEY);
    pix(0, 0, 1'b1, 12'h0F0);
    drain();

    // asynchronous reset in the middle of a hit run
    repeat (3) @(negedge clk);
    check("pre_reset", {sprite_hit, sprite_rgb}, {1'b1, 12'h0F0});
    #2 reset = 1'b1;
    #1 check("async_reset", {sprite_hit, sprite_rgb}, {1'b0, KEY});
    @(negedge clk);
    reset = 1'b0;
    pix(0, 0, 1'b0, KEY);
    set_desc(0, 0, 0, 3'b001, 1'b1, 1'b0);
    pix(0, 0, 1'b1, 12'h00F);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
